// File: rtl/skip_buf_arbiter.sv
// skip_buf_arbiter: grants whole-line bursts from five encoder/decoder layers
// onto one shared skip memory; reads win over writes, round-robin within each class.
module skip_buf_arbiter #(
  parameter int unsigned LINES  = 8,
  parameter int unsigned BURST0 = 224,
  parameter int unsigned BURSTN = 112
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  req_wr,
  input  logic [4:0]  req_rd,
  output logic [4:0]  wr_gnt,
  output logic [4:0]  rd_gnt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic        burst_last,
  output logic [4:0]  full,
  output logic [4:0]  empty,
  output logic        busy
);

  localparam int unsigned NL = 5;
  localparam int unsigned LW = 3;
  localparam int unsigned WW = 8;
  localparam int unsigned OW = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    WR_BURST = 3'd2,
    RD_BURST = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t        state;
  logic [OW-1:0] occ  [NL];
  logic [LW-1:0] wptr [NL];
  logic [LW-1:0] rptr [NL];
  logic [LW-1:0] rr_wr, rr_rd, cur;
  logic [WW-1:0] word;

  logic [NL-1:0] elig_wr_c, elig_rd_c;
  logic [LW-1:0] sel_wr_c, sel_rd_c;
  logic [WW-1:0] last_word_c;

  // First eligible index after ptr, wrapping mod NL; smallest offset wins.
  function automatic logic [LW-1:0] rr_pick(input logic [NL-1:0] elig, input logic [LW-1:0] ptr);
    logic [LW-1:0] pick;
    logic [LW-1:0] idx;
    pick = '0;
    for (int k = NL; k >= 1; k--) begin
      idx = LW'((int'(ptr) + k) % NL);
      if (elig[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    elig_wr_c   = req_wr & ~full;
    elig_rd_c   = req_rd & ~empty;
    sel_wr_c    = rr_pick(elig_wr_c, rr_wr);
    sel_rd_c    = rr_pick(elig_rd_c, rr_rd);
    last_word_c = (cur == '0) ? WW'(BURST0 - 1) : WW'(BURSTN - 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_gnt     <= '0;
      rd_gnt     <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      burst_last <= 1'b0;
      busy       <= 1'b0;
      full       <= '0;
      empty      <= '1;
      rr_wr      <= LW'(4);
      rr_rd      <= LW'(4);
      cur        <= '0;
      word       <= '0;
      for (int i = 0; i < NL; i++) begin
        occ[i]  <= '0;
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: state <= ARB;
        ARB: begin
          if (|elig_rd_c) begin
            state    <= RD_BURST;
            busy     <= 1'b1;
            cur      <= sel_rd_c;
            rr_rd    <= sel_rd_c;
            rd_gnt   <= NL'(1) << sel_rd_c;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {sel_rd_c, rptr[sel_rd_c], WW'(0)};
            word     <= '0;
          end else if (|elig_wr_c) begin
            state    <= WR_BURST;
            busy     <= 1'b1;
            cur      <= sel_wr_c;
            rr_wr    <= sel_wr_c;
            wr_gnt   <= NL'(1) << sel_wr_c;
            mem_en   <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= {sel_wr_c, wptr[sel_wr_c], WW'(0)};
            word     <= '0;
          end
        end
        WR_BURST, RD_BURST: begin
          if (burst_last) begin
            state      <= GAP;
            wr_gnt     <= '0;
            rd_gnt     <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            burst_last <= 1'b0;
            // Line committed or released only once the whole burst is through.
            if (state == WR_BURST) begin
              occ[cur]   <= occ[cur] + OW'(1);
              wptr[cur]  <= LW'((int'(wptr[cur]) + 1) % LINES);
              full[cur]  <= ((occ[cur] + OW'(1)) == OW'(LINES));
              empty[cur] <= 1'b0;
            end else begin
              occ[cur]   <= occ[cur] - OW'(1);
              rptr[cur]  <= LW'((int'(rptr[cur]) + 1) % LINES);
              full[cur]  <= 1'b0;
              empty[cur] <= (occ[cur] == OW'(1));
            end
          end else begin
            word               <= word + WW'(1);
            mem_addr[WW-1:0]   <= word + WW'(1);
            burst_last         <= ((word + WW'(1)) == last_word_c);
          end
        end
        GAP: begin
          state <= ARB;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          wr_gnt     <= '0;
          rd_gnt     <= '0;
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          mem_addr   <= '0;
          burst_last <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skip_buf_arbiter.sv
// tb_skip_buf_arbiter: directed scenarios against a transaction-level model of
// the skip buffer arbiter, plus literal expectations on the recorded bursts.
module tb_skip_buf_arbiter;

  localparam int LINES  = 8;
  localparam int BURST0 = 224;
  localparam int BURSTN = 112;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  req_wr = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  wr_gnt, rd_gnt, full, empty;
  logic        mem_en, mem_we, burst_last, busy;
  logic [13:0] mem_addr;

  always #5 clk = ~clk;

  skip_buf_arbiter #(.LINES(LINES), .BURST0(BURST0), .BURSTN(BURSTN)) dut (
    .clk(clk), .reset_n(reset_n), .req_wr(req_wr), .req_rd(req_rd),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .burst_last(burst_last), .full(full), .empty(empty), .busy(busy)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: occupancy counters, line pointers, one burst in flight.
  typedef enum {M_IDLE, M_ARB, M_BURST, M_GAP} mphase_t;
  mphase_t m_ph;
  int m_occ [5];
  int m_wp  [5];
  int m_rp  [5];
  int m_last_wr, m_last_rd, m_layer, m_word;
  bit m_wr;
  bit [4:0] m_er, m_ew;

  function automatic int blen(input int l);
    return (l == 0) ? BURST0 : BURSTN;
  endfunction

  function automatic int rr(input bit [4:0] el, input int last);
    for (int k = 1; k <= 5; k++)
      if (el[(last + k) % 5]) return (last + k) % 5;
    return 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = M_IDLE;
      for (int i = 0; i < 5; i++) begin m_occ[i] = 0; m_wp[i] = 0; m_rp[i] = 0; end
      m_last_wr = 4; m_last_rd = 4; m_layer = 0; m_word = 0; m_wr = 0;
    end else begin
      case (m_ph)
        M_IDLE: m_ph = M_ARB;
        M_ARB: begin
          for (int i = 0; i < 5; i++) begin
            m_er[i] = req_rd[i] && (m_occ[i] > 0);
            m_ew[i] = req_wr[i] && (m_occ[i] < LINES);
          end
          if (m_er != 0) begin
            m_layer = rr(m_er, m_last_rd); m_last_rd = m_layer; m_wr = 0; m_word = 0; m_ph = M_BURST;
          end else if (m_ew != 0) begin
            m_layer = rr(m_ew, m_last_wr); m_last_wr = m_layer; m_wr = 1; m_word = 0; m_ph = M_BURST;
          end
        end
        M_BURST: begin
          if (m_word == blen(m_layer) - 1) begin
            if (m_wr) begin m_occ[m_layer]++; m_wp[m_layer] = (m_wp[m_layer] + 1) % LINES; end
            else      begin m_occ[m_layer]--; m_rp[m_layer] = (m_rp[m_layer] + 1) % LINES; end
            m_ph = M_GAP;
          end else m_word++;
        end
        default: m_ph = M_ARB;
      endcase
    end
  end

  // Burst log built from DUT outputs, used for the literal expectations.
  typedef struct { bit wr; int layer; int start; int len; int last; int sc; int ec; } brec_t;
  brec_t blog [$];
  brec_t cur_b;
  bit    in_b = 0;
  bit    cmp_on = 0;
  int    cyc = 0;
  logic [4:0]  e_wg, e_rg, e_full, e_empty, g;
  logic        e_en, e_we, e_last, e_busy;
  logic [13:0] e_addr;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cmp_on) begin
      e_en   = (m_ph == M_BURST);
      e_we   = e_en && m_wr;
      e_wg   = (e_en && m_wr)  ? 5'(1 << m_layer) : 5'd0;
      e_rg   = (e_en && !m_wr) ? 5'(1 << m_layer) : 5'd0;
      e_last = e_en && (m_word == blen(m_layer) - 1);
      e_busy = (m_ph == M_BURST) || (m_ph == M_GAP);
      e_addr = 14'(m_layer * 2048 + (m_wr ? m_wp[m_layer] : m_rp[m_layer]) * 256 + m_word);
      for (int i = 0; i < 5; i++) begin
        e_full[i]  = (m_occ[i] == LINES);
        e_empty[i] = (m_occ[i] == 0);
      end
      check("grants", 32'({wr_gnt, rd_gnt}), 32'({e_wg, e_rg}));
      check("mem_ctl", 32'({mem_en, mem_we, burst_last, busy}), 32'({e_en, e_we, e_last, e_busy}));
      if (e_en) check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("full_empty", 32'({full, empty}), 32'({e_full, e_empty}));
    end
    if (!reset_n) in_b = 0;
    else if (mem_en) begin
      if (!in_b) begin
        in_b = 1;
        g = wr_gnt | rd_gnt;
        cur_b.layer = -1;
        for (int i = 0; i < 5; i++) if (g[i]) cur_b.layer = i;
        cur_b.wr = mem_we; cur_b.start = int'(mem_addr); cur_b.len = 0; cur_b.sc = cyc;
      end
      cur_b.len++;
      if (burst_last) begin
        cur_b.last = int'(mem_addr); cur_b.ec = cyc;
        blog.push_back(cur_b);
        in_b = 0;
      end
    end
  end

  task automatic chk_reset(input string tag);
    check({tag, "_gnt"}, 32'({wr_gnt, rd_gnt}), 32'd0);
    check({tag, "_ctl"}, 32'({mem_en, mem_we, burst_last, busy}), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_flags"}, 32'({full, empty}), 32'h01F);
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    while (blog.size() < n && budget > 0) begin @(negedge clk); budget--; end
    check({tag, "_count"}, 32'(blog.size() >= n), 32'd1);
  endtask

  task automatic wait_en(input string tag, input int budget);
    while (!mem_en && budget > 0) begin @(negedge clk); budget--; end
    check({tag, "_start"}, 32'(mem_en), 32'd1);
  endtask

  task automatic chk_burst(input string tag, input int idx, input bit wr, input int layer,
                           input int start, input int len);
    brec_t r;
    if (idx >= blog.size()) begin
      check({tag, "_present"}, 32'(blog.size()), 32'(idx + 1));
      return;
    end
    r = blog[idx];
    check({tag, "_dir"},   32'(r.wr), 32'(wr));
    check({tag, "_layer"}, r.layer, layer);
    check({tag, "_start"}, r.start, start);
    check({tag, "_len"},   r.len, len);
    check({tag, "_last"},  r.last, start + len - 1);
  endtask

  int base;
  bit seen_en;
  int exp_layer [6] = '{0, 1, 2, 3, 4, 0};
  int exp_start [6] = '{'h0000, 'h0800, 'h1000, 'h1800, 'h2000, 'h0100};

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;
    cmp_on  = 1'b1;

    // read on an empty layer is masked
    req_rd = 5'b10000;
    seen_en = 0;
    repeat (20) begin @(negedge clk); if (mem_en) seen_en = 1; end
    check("rd_empty_no_en", 32'(seen_en), 32'd0);
    check("rd_empty_busy", 32'(busy), 32'd0);
    check("rd_empty_log", 32'(blog.size()), 32'd0);
    req_rd = '0;

    // single layer-0 write, request dropped mid-burst
    req_wr = 5'b00001;
    wait_en("w0", 20);
    req_wr = '0;
    wait_log("w0", 1, 400);
    chk_burst("w0", 0, 1, 0, 'h0000, 224);
    @(negedge clk);
    check("w0_empty", 32'(empty), 32'h1E);

    // all layers writing: round robin from layer 0 after a fresh reset
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    base = blog.size();
    req_wr = 5'b11111;
    wait_log("rr", base + 6, 2000);
    req_wr = '0;
    for (int k = 0; k < 6; k++)
      chk_burst($sformatf("rr%0d", k), base + k, 1, exp_layer[k], exp_start[k], blen(exp_layer[k]));
    for (int k = 0; k < 5; k++)
      if (base + k + 1 < blog.size())
        check($sformatf("rr_gap%0d", k), blog[base + k + 1].sc, blog[base + k].ec + 3);

    // read of layer 2 beats simultaneous write to layer 3
    repeat (4) @(negedge clk);
    base = blog.size();
    req_wr = 5'b01000;
    req_rd = 5'b00100;
    wait_log("rw", base + 2, 600);
    req_wr = '0;
    req_rd = '0;
    chk_burst("rw_rd", base, 0, 2, 'h1000, 112);
    chk_burst("rw_wr", base + 1, 1, 3, 'h1900, 112);

    // fill layer 1, masked ninth write, one read frees a line and pointer wraps
    repeat (4) @(negedge clk);
    base = blog.size();
    req_wr = 5'b00010;
    begin
      int budget = 1500;
      while (!full[1] && budget > 0) begin @(negedge clk); budget--; end
    end
    check("fill_full", 32'(full[1]), 32'd1);
    check("fill_count", 32'(blog.size() - base), 32'd7);
    chk_burst("fill_last", base + 6, 1, 1, 'h0F00, 112);
    repeat (300) @(negedge clk);
    check("full_masked", 32'(blog.size() - base), 32'd7);
    req_rd = 5'b00010;
    wait_log("free", base + 8, 300);
    req_rd = '0;
    chk_burst("free_rd", base + 7, 0, 1, 'h0800, 112);
    @(negedge clk);
    check("free_notfull", 32'(full[1]), 32'd0);
    wait_log("wrap", base + 9, 300);
    req_wr = '0;
    chk_burst("wrap_wr", base + 8, 1, 1, 'h0800, 112);

    // reset in the middle of a layer-0 write
    repeat (4) @(negedge clk);
    req_wr = 5'b00001;
    wait_en("ab", 20);
    req_wr = '0;
    begin
      int budget = 100;
      while (mem_addr[7:0] != 8'd50 && budget > 0) begin @(negedge clk); budget--; end
    end
    check("ab_word50", 32'(mem_addr), 32'h0232);
    reset_n = 1'b0;
    #1;
    chk_reset("ab_rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("ab_empty", 32'(empty), 32'h1F);
    base = blog.size();
    req_wr = 5'b00001;
    wait_en("ab2", 20);
    req_wr = '0;
    wait_log("ab2", base + 1, 400);
    chk_burst("ab2", base, 1, 0, 'h0000, 224);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", passes, checks);
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

endmodule
